sic1_loader: RTL and testbench

SIC1_LOADER -- requirements
Module: sic1_loader

---
 rtl/sic1_loader.sv | 185 ++++++++++++++++++
 tb/tb_sic1_loader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sic1_loader.sv
// Byte-stream frame loader for a SIC-1 core: writes a program, sets the PC, runs until halt.
// Optional trailing checksum byte when SIC1_LOADER_CHECKSUM_EN is defined.
module sic1_loader (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] core_ui_in,
  output logic       core_set_pc,
  output logic       core_set_data,
  output logic       core_run,
  input  logic       core_halted,
  output logic       done,
  output logic       err
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_HLEN,
    S_HENTRY,
    S_LOAD,
`ifdef SIC1_LOADER_CHECKSUM_EN
    S_CKSUM,
`endif
    S_DRAIN,
    S_SETPC,
    S_GAP,
    S_RUN
  } state_t;

`ifdef SIC1_LOADER_CHECKSUM_EN
  localparam state_t POST_DATA = S_CKSUM;
  localparam state_t DRAIN_END = S_CKSUM;
`else
  localparam state_t POST_DATA = S_SETPC;
  localparam state_t DRAIN_END = S_IDLE;
`endif

  state_t     state_q;
  logic [7:0] start_q;
  logic [7:0] len_q;
  logic [7:0] entry_q;
  logic [7:0] cnt_q;
  logic [1:0] run_cnt_q;
  logic [7:0] ui_in_q;
  logic       set_pc_q;
  logic       set_data_q;
  logic       run_q;
  logic       done_q;
  logic       err_q;
`ifdef SIC1_LOADER_CHECKSUM_EN
  logic [7:0] sum_q;
`endif

  logic       accept;
  logic [8:0] end_addr;
  logic       hdr_bad;

  assign in_ready = (state_q != S_SETPC) && (state_q != S_GAP);
  assign accept   = in_valid && in_ready;
  assign end_addr = {1'b0, start_q} + {1'b0, len_q};
  assign hdr_bad  = (end_addr > 9'd256) || (in_data > 8'd252);

  assign core_ui_in    = ui_in_q;
  assign core_set_pc   = set_pc_q;
  assign core_set_data = set_data_q;
  assign core_run      = run_q;
  assign done          = done_q;
  assign err           = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      start_q    <= 8'd0;
      len_q      <= 8'd0;
      entry_q    <= 8'd0;
      cnt_q      <= 8'd0;
      run_cnt_q  <= 2'd0;
      ui_in_q    <= 8'd0;
      set_pc_q   <= 1'b0;
      set_data_q <= 1'b0;
      run_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef SIC1_LOADER_CHECKSUM_EN
      sum_q      <= 8'd0;
`endif
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      set_pc_q   <= 1'b0;
      set_data_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            start_q  <= in_data;
            err_q    <= 1'b0;
            set_pc_q <= 1'b1;
            ui_in_q  <= in_data;
            state_q  <= S_HLEN;
          end
        end
        S_HLEN: begin
          if (accept) begin
            len_q   <= in_data;
            cnt_q   <= in_data;
            state_q <= S_HENTRY;
          end
        end
        S_HENTRY: begin
          if (accept) begin
            entry_q <= in_data;
`ifdef SIC1_LOADER_CHECKSUM_EN
            sum_q   <= 8'd0;
`endif
            if (hdr_bad) begin
              err_q   <= 1'b1;
              state_q <= (len_q == 8'd0) ? DRAIN_END : S_DRAIN;
            end else begin
              state_q <= (len_q == 8'd0) ? POST_DATA : S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (accept) begin
            set_data_q <= 1'b1;
            ui_in_q    <= in_data;
            cnt_q      <= cnt_q - 8'd1;
`ifdef SIC1_LOADER_CHECKSUM_EN
            sum_q      <= sum_q + in_data;
`endif
            if (cnt_q == 8'd1) state_q <= POST_DATA;
          end
        end
`ifdef SIC1_LOADER_CHECKSUM_EN
        S_CKSUM: begin
          // err_q here can only have been set by this frame's header check.
          if (accept) begin
            if (err_q) begin
              state_q <= S_IDLE;
            end else if (in_data == sum_q) begin
              state_q <= S_SETPC;
            end else begin
              err_q   <= 1'b1;
              state_q <= S_IDLE;
            end
          end
        end
`endif
        S_DRAIN: begin
          if (accept) begin
            cnt_q <= cnt_q - 8'd1;
            if (cnt_q == 8'd1) state_q <= DRAIN_END;
          end
        end
        S_SETPC: begin
          set_pc_q <= 1'b1;
          ui_in_q  <= entry_q;
          state_q  <= S_GAP;
        end
        S_GAP: begin
          run_cnt_q <= 2'd0;
          state_q   <= S_RUN;
        end
        S_RUN: begin
          // RUN cycles 0 and 1 ignore core_halted; run rises after cycle 0.
          if (accept) begin
            run_q   <= 1'b0;
            state_q <= S_IDLE;
          end else if (run_cnt_q != 2'd2) begin
            run_q     <= 1'b1;
            run_cnt_q <= run_cnt_q + 2'd1;
          end else if (core_halted) begin
            run_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sic1_loader.sv
// Scoreboard bench for sic1_loader: frame-level reference model pushes expected core events,
// a negedge monitor pops them. Honours SIC1_LOADER_CHECKSUM_EN like the design.
module tb_sic1_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] core_ui_in;
  logic       core_set_pc;
  logic       core_set_data;
  logic       core_run;
  logic       core_halted = 1'b0;
  logic       done;
  logic       err;

  always #5 clk = ~clk;

  sic1_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .core_ui_in   (core_ui_in),
    .core_set_pc  (core_set_pc),
    .core_set_data(core_set_data),
    .core_run     (core_run),
    .core_halted  (core_halted),
    .done         (done),
    .err          (err)
  );

`ifdef SIC1_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  localparam logic [7:0] EV_PC = 8'd1, EV_DATA = 8'd2, EV_RUN = 8'd3,
                         EV_FALL = 8'd4, EV_DONE = 8'd5, EV_ERR = 8'd6;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  dat[8];

  function automatic string ev_name(input logic [7:0] k);
    case (k)
      EV_PC:   return "set_pc";
      EV_DATA: return "set_data";
      EV_RUN:  return "run_rise";
      EV_FALL: return "run_fall_len";
      EV_DONE: return "done";
      EV_ERR:  return "err_rise";
      default: return "unknown";
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic observe(input logic [7:0] kind, input logic [7:0] val);
    logic [15:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got %s %02h, required no event", ev_name(kind), val);
    end else begin
      e = exp_q.pop_front();
      if (e !== {kind, val}) begin
        errors++;
        $display("FAIL event_%s: got %s %02h, required %s %02h",
                 ev_name(e[15:8]), ev_name(kind), val, ev_name(e[15:8]), e[7:0]);
      end
    end
  endtask

  // Monitor
  logic run_prev = 1'b0;
  logic err_prev = 1'b0;
  int   run_len  = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      run_prev = 1'b0;
      err_prev = 1'b0;
      run_len  = 0;
    end else begin
      check("strobe_exclusive",
            {core_set_pc && core_set_data, (core_set_pc || core_set_data) && core_run}, 0);
      if (core_set_pc)   observe(EV_PC, core_ui_in);
      if (core_set_data) observe(EV_DATA, core_ui_in);
      if (core_run && !run_prev) observe(EV_RUN, 8'd0);
      if (core_run) run_len++;
      if (!core_run && run_prev) begin
        observe(EV_FALL, run_len[7:0]);
        run_len = 0;
      end
      if (done) observe(EV_DONE, 8'd0);
      if (err && !err_prev) observe(EV_ERR, 8'd0);
      run_prev = core_run;
      err_prev = err;
    end
  end

  // Entered and left at posedge+1.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = b;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 40) begin
        checks++; errors++;
        $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles, required 1", n);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // mode 0: halted held from before RUN; mode 1: halted raised in run-high cycle k;
  // mode 2: abort byte sent in run-high cycle 1+k.
  task automatic do_frame(input logic [7:0] s, input logic [7:0] l, input logic [7:0] e,
                          input int mode, input int k, input bit bad_ck);
    int         sum = 0;
    int         n;
    bit         hdr_bad;
    bit         go;
    logic [7:0] ck8;
    core_halted = 1'b0;
    for (int i = 0; i < int'(l); i++) sum += int'(dat[i]);
    ck8     = sum[7:0] + (bad_ck ? 8'd1 : 8'd0);
    hdr_bad = (int'(s) + int'(l) > 256) || (e > 8'd252);
    go      = !hdr_bad && !(CK && bad_ck);
    $display("frame start=%02h len=%0d entry=%02h mode=%0d k=%0d bad_ck=%0d expect_run=%0d",
             s, l, e, mode, k, bad_ck, go);
    exp_q.push_back({EV_PC, s});
    if (hdr_bad) begin
      exp_q.push_back({EV_ERR, 8'd0});
    end else begin
      for (int i = 0; i < int'(l); i++) exp_q.push_back({EV_DATA, dat[i]});
      if (!go) begin
        exp_q.push_back({EV_ERR, 8'd0});
      end else begin
        exp_q.push_back({EV_PC, e});
        exp_q.push_back({EV_RUN, 8'd0});
        if (mode == 2) begin
          exp_q.push_back({EV_FALL, 8'(1 + k)});
        end else begin
          exp_q.push_back({EV_FALL, 8'((mode == 0 || k < 2) ? 2 : k)});
          exp_q.push_back({EV_DONE, 8'd0});
        end
      end
    end
    send_byte(s);
    send_byte(l);
    send_byte(e);
    for (int i = 0; i < int'(l); i++) send_byte(dat[i]);
    if (CK) send_byte(ck8);
    if (mode == 0) core_halted = 1'b1;
    if (go) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!core_run && n < 60);
      if (!core_run) begin
        checks++; errors++;
        $display("FAIL run_timeout: got core_run=0 after %0d cycles, required 1", n);
      end else begin
        if (mode == 1) begin
          repeat (k - 1) @(negedge clk);
          core_halted = 1'b1;
        end else if (mode == 2) begin
          repeat (k) @(negedge clk);
          in_valid = 1'b1;
          in_data  = 8'($urandom);
          @(posedge clk); #1;
          in_valid = 1'b0;
        end
        n = 0;
        while (core_run && n < 60) begin @(negedge clk); n++; end
        if (core_run) begin
          checks++; errors++;
          $display("FAIL halt_timeout: got core_run=1 after %0d cycles, required 0", n);
        end
        check("err_clear_after_run", err, 0);
      end
    end else begin
      repeat (3) @(negedge clk);
      check("err_sticky", err, 1);
    end
    core_halted = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #12;
    check("reset_ui_in", core_ui_in, 0);
    check("reset_strobes", {core_set_pc, core_set_data, core_run, done, err}, 0);
    check("reset_in_ready", in_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    dat[0] = 8'hAA; dat[1] = 8'hBB; dat[2] = 8'hCC;
    do_frame(8'h10, 8'd3, 8'h10, 0, 0, 1'b0);
    for (int i = 0; i < 8; i++) dat[i] = 8'($urandom);
    do_frame(8'hFE, 8'd5, 8'h00, 0, 0, 1'b0);
    do_frame(8'h20, 8'd2, 8'h21, 1, 3, 1'b0);
    do_frame(8'h00, 8'd0, 8'hFD, 0, 0, 1'b0);
    dat[0] = 8'h01; dat[1] = 8'h02;
    do_frame(8'h00, 8'd2, 8'h00, 1, 1, 1'b1);
    do_frame(8'h00, 8'd2, 8'h00, 1, 4, 1'b0);
    do_frame(8'hF8, 8'd8, 8'hFC, 0, 0, 1'b0);
    do_frame(8'hF9, 8'd8, 8'h10, 0, 0, 1'b0);
    do_frame(8'h30, 8'd0, 8'h40, 2, 0, 1'b0);
    do_frame(8'h31, 8'd1, 8'h31, 2, 3, 1'b0);

    // Reset while a set_data strobe is visible.
    for (int i = 0; i < 4; i++) dat[i] = 8'($urandom);
    $display("frame start=20 len=4 entry=30 reset after second data byte");
    exp_q.push_back({EV_PC, 8'h20});
    exp_q.push_back({EV_DATA, dat[0]});
    exp_q.push_back({EV_DATA, dat[1]});
    send_byte(8'h20); send_byte(8'd4); send_byte(8'h30);
    send_byte(dat[0]); send_byte(dat[1]);
    check("pre_reset_set_data", core_set_data, 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_ui_in", core_ui_in, 0);
    check("async_reset_strobes", {core_set_pc, core_set_data, core_run, done, err}, 0);
    exp_q.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    dat[0] = 8'h5A; dat[1] = 8'hA5;
    do_frame(8'h40, 8'd2, 8'h40, 1, 2, 1'b0);

    for (int f = 0; f < 25; f++) begin
      logic [7:0] s, l, e;
      int mode, k;
      for (int i = 0; i < 8; i++) dat[i] = 8'($urandom);
      s    = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(8'hF0, 8'hFF)) : 8'($urandom);
      l    = 8'($urandom_range(0, 8));
      e    = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'($urandom_range(0, 252));
      mode = $urandom_range(0, 2);
      k    = (mode == 1) ? $urandom_range(1, 4) : (mode == 2) ? $urandom_range(0, 4) : 0;
      do_frame(s, l, e, mode, k, ($urandom_range(0, 4) == 0));
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
